// File: rtl/fetch_sequencer_pkg.sv
// fetch_pkg: PC-source and sequencer-state encodings shared by the fetch
// sequencer, its interface and the bench.
package fetch_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ     = 2'b00,   // PC+4 of the instruction in F
        PCSRC_RESTORE = 2'b01,   // PC+4 of the instruction in E
        PCSRC_TARGET  = 2'b10,   // ALU-computed target from E
        PCSRC_RESET   = 2'b11    // reset vector 0
    } pc_source_t;

    typedef enum logic [1:0] {
        FS_BOOT     = 2'b00,
        FS_RUN      = 2'b01,
        FS_WAIT_MEM = 2'b10,
        FS_HALT     = 2'b11
    } fetch_state_t;

    // Where a redirect lands: a jump or a taken branch goes to the ALU target.
    // A branch wrongly predicted taken restarts at its own PC+4.
    function automatic pc_source_t redirect_source(input logic jump, input logic taken);
        pc_source_t src;
        if (jump || taken) begin
            src = PCSRC_TARGET;
        end else begin
            src = PCSRC_RESTORE;
        end
        return src;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: hazard, branch-resolution and instruction-memory
// handshake signals between the fetch sequencer (master) and the fetch
// datapath/pipeline (slave).
interface fetch_sequencer_if;

    logic       stall_D;
    logic       halt_req;
    logic       imem_ready;
    logic       branch_E;
    logic       jump_E;
    logic       taken_E;
    logic       predicted_E;
    logic       target_miss_E;
    logic       predict_raw_D;

    logic       enable_fetch;
    logic [1:0] PC_source_E;
    logic       branch_prediction_D;
    logic       flush_D;
    logic       flush_E;
    logic       imem_request;
    logic       halted;

    modport master (
        input  stall_D, halt_req, imem_ready, branch_E, jump_E, taken_E,
               predicted_E, target_miss_E, predict_raw_D,
        output enable_fetch, PC_source_E, branch_prediction_D, flush_D,
               flush_E, imem_request, halted
    );

    modport slave (
        output stall_D, halt_req, imem_ready, branch_E, jump_E, taken_E,
               predicted_E, target_miss_E, predict_raw_D,
        input  enable_fetch, PC_source_E, branch_prediction_D, flush_D,
               flush_E, imem_request, halted
    );

endinterface

// File: rtl/saturating_counter_N.sv
// saturating_counter_N: N-bit event counter that sticks at all-ones.
module saturating_counter_N #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         async_reset,
    input  logic         inc,
    output logic [N-1:0] count
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    // Count qualifying events, holding at the maximum value.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            count <= {N{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: RV32I fetch-stage control. Sequences PC source/enable,
// gates the decode-stage prediction, and issues D/E flushes on redirect.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic               clock,
    input  logic               async_reset,
    fetch_sequencer_if.master  fetch
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]        redirect_count,
    output logic [31:0]        stall_count
`endif
);

    localparam logic [1:0] ST_BOOT     = 2'b00;
    localparam logic [1:0] ST_RUN      = 2'b01;
    localparam logic [1:0] ST_WAIT_MEM = 2'b10;
    localparam logic [1:0] ST_HALT     = 2'b11;

    // BOOT is left when the counter reaches zero, so BOOT_CYCLES-1 gives
    // exactly BOOT_CYCLES cycles in BOOT after reset release.
    localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [3:0] boot_cnt_r;

    logic       rd_s;
    logic       rd_taken_s;
    logic       stall_evt_s;
    logic       enable_s;
    logic [1:0] src_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic       request_s;
    logic       halted_s;
    logic       bp_s;

    // Redirect when E resolves differently from how the front end fetched.
    always_comb begin
        rd_s = fetch.jump_E
             | (fetch.branch_E & (fetch.taken_E ^ fetch.predicted_E))
             | (fetch.branch_E & fetch.taken_E & fetch.target_miss_E);
    end

    // Output decode and next-state selection for the fetch front end.
    always_comb begin
        enable_s     = 1'b0;
        src_s        = PCSRC_SEQ;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        request_s    = 1'b0;
        halted_s     = 1'b0;
        rd_taken_s   = 1'b0;
        stall_evt_s  = 1'b0;
        state_next_s = state_r;

        if (async_reset) begin
            // Reset values apply while reset is held, not just after the edge.
            src_s        = PCSRC_RESET;
            state_next_s = ST_BOOT;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    src_s     = PCSRC_RESET;
                    enable_s  = 1'b1;
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (boot_cnt_r == 4'd0) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_BOOT;
                    end
                end
                ST_RUN, ST_WAIT_MEM: begin
                    request_s = 1'b1;
                    if (rd_s) begin
                        // Abandons any outstanding fetch; the new PC is requested next.
                        enable_s     = 1'b1;
                        flush_d_s    = 1'b1;
                        flush_e_s    = 1'b1;
                        src_s        = redirect_source(fetch.jump_E, fetch.taken_E);
                        rd_taken_s   = 1'b1;
                        state_next_s = ST_RUN;
                    end else if (fetch.halt_req) begin
                        state_next_s = ST_HALT;
                    end else if (fetch.stall_D) begin
                        flush_e_s    = 1'b1;
                        state_next_s = state_r;
                    end else if (!fetch.imem_ready) begin
                        flush_d_s    = 1'b1;
                        state_next_s = ST_WAIT_MEM;
                    end else begin
                        enable_s     = 1'b1;
                        state_next_s = ST_RUN;
                    end
                    stall_evt_s = ~enable_s;
                end
                ST_HALT: begin
                    halted_s = 1'b1;
                    if (rd_s) begin
                        // An older instruction still in E may redirect while halted.
                        enable_s     = 1'b1;
                        flush_d_s    = 1'b1;
                        flush_e_s    = 1'b1;
                        src_s        = redirect_source(fetch.jump_E, fetch.taken_E);
                        rd_taken_s   = 1'b1;
                        state_next_s = ST_HALT;
                    end else if (!fetch.halt_req) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end
                default: begin
                    src_s        = PCSRC_RESET;
                    state_next_s = ST_BOOT;
                end
            endcase
        end

        bp_s = fetch.predict_raw_D & enable_s & ~flush_d_s;
    end

    // Sequencer state and boot countdown.
    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_r    <= ST_BOOT;
            boot_cnt_r <= BOOT_LOAD;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_BOOT) && (boot_cnt_r != 4'd0)) begin
                boot_cnt_r <= boot_cnt_r - 4'd1;
            end else begin
                boot_cnt_r <= boot_cnt_r;
            end
        end
    end

    assign fetch.enable_fetch        = enable_s;
    assign fetch.PC_source_E         = src_s;
    assign fetch.branch_prediction_D = bp_s;
    assign fetch.flush_D             = flush_d_s;
    assign fetch.flush_E             = flush_e_s;
    assign fetch.imem_request        = request_s;
    assign fetch.halted              = halted_s;

`ifdef FETCH_SEQ_PERF_EN
    saturating_counter_N #(.N(32)) u_redirect_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .inc         (rd_taken_s),
        .count       (redirect_count)
    );

    saturating_counter_N #(.N(32)) u_stall_cnt (
        .clock       (clock),
        .async_reset (async_reset),
        .inc         (stall_evt_s),
        .count       (stall_count)
    );
`else
    logic unused_perf_s;
    assign unused_perf_s = rd_taken_s ^ stall_evt_s;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-vector bench for fetch_sequencer. Inputs change
// on the falling edge; combinational outputs are sampled 1 time unit later.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic clock;
    logic async_reset;
    int   vectors;
    int   miscompares;

    fetch_sequencer_if bus ();

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] redirect_count;
    logic [31:0] stall_count;
`endif

    fetch_sequencer #(.BOOT_CYCLES(2)) dut (
        .clock       (clock),
        .async_reset (async_reset),
        .fetch       (bus)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .redirect_count (redirect_count),
        .stall_count    (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input vector at the falling edge and let it settle.
    task automatic step(input logic b, input logic j, input logic t, input logic p,
                        input logic tm, input logic raw, input logic st,
                        input logic hl, input logic rdy);
        @(negedge clock);
        bus.branch_E      = b;
        bus.jump_E        = j;
        bus.taken_E       = t;
        bus.predicted_E   = p;
        bus.target_miss_E = tm;
        bus.predict_raw_D = raw;
        bus.stall_D       = st;
        bus.halt_req      = hl;
        bus.imem_ready    = rdy;
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic en, input logic [1:0] src,
                               input logic bp, input logic fd, input logic fe,
                               input logic req, input logic hlt);
        check({tag, ".en"},   {31'd0, bus.enable_fetch},        {31'd0, en});
        check({tag, ".src"},  {30'd0, bus.PC_source_E},         {30'd0, src});
        check({tag, ".bp"},   {31'd0, bus.branch_prediction_D}, {31'd0, bp});
        check({tag, ".fd"},   {31'd0, bus.flush_D},             {31'd0, fd});
        check({tag, ".fe"},   {31'd0, bus.flush_E},             {31'd0, fe});
        check({tag, ".req"},  {31'd0, bus.imem_request},        {31'd0, req});
        check({tag, ".halt"}, {31'd0, bus.halted},              {31'd0, hlt});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        async_reset = 1'b1;
        bus.branch_E = 1'b0; bus.jump_E = 1'b0; bus.taken_E = 1'b0;
        bus.predicted_E = 1'b0; bus.target_miss_E = 1'b0; bus.predict_raw_D = 1'b1;
        bus.stall_D = 1'b0; bus.halt_req = 1'b0; bus.imem_ready = 1'b1;

        // Reset held: everything 0 except the reset-vector source.
        repeat (2) @(negedge clock);
        #1;
        expect_outs("reset", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release: two BOOT cycles, then RUN.
        @(negedge clock);
        async_reset = 1'b0;
        #1;
        expect_outs("boot1", 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(0,0,0,0,0, 1, 0,0,1);
        expect_outs("boot2", 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("run0", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Predicted not-taken, actually taken: target, flush, prediction squashed.
        step(1,0,1,0,0, 1, 0,0,1);
        expect_outs("mis_taken", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(0,0,0,0,0, 1, 0,0,1);
        expect_outs("pred_pass", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Predicted taken, actually not taken: restore PC+4 of E.
        step(1,0,0,1,0, 1, 0,0,1);
        expect_outs("mis_ntaken", 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Correctly predicted not-taken: no redirect.
        step(1,0,0,0,0, 0, 0,0,1);
        expect_outs("ok_ntaken", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Predicted taken but to the wrong target.
        step(1,0,1,1,1, 1, 0,0,1);
        expect_outs("tgt_miss", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        // Predicted taken to the right target.
        step(1,0,1,1,0, 1, 0,0,1);
        expect_outs("ok_taken", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Three memory wait cycles, then resume.
        for (int i = 0; i < 3; i++) begin
            step(0,0,0,0,0, 1, 0,0,0);
            expect_outs("wait", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("resume", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Jump arriving during a wait wins over the wait.
        step(0,0,0,0,0, 0, 0,0,0);
        expect_outs("wait2", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(0,1,0,0,0, 1, 0,0,0);
        expect_outs("jump_wait", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("after_jump", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stall beats memory not-ready.
        step(0,0,0,0,0, 1, 1,0,0);
        expect_outs("stall_wait", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Halt held for 4 cycles, then released.
        step(0,0,0,0,0, 0, 0,1,1);
        expect_outs("halt_req", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0,0,0,0,0, 1, 0,1,1);
            expect_outs("halted", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("halt_rel", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("run_again", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Redirect in HALT loads the PC but stays halted.
        step(0,0,0,0,0, 0, 0,1,1);
        step(0,1,0,0,0, 0, 0,1,1);
        expect_outs("halt_jump", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(0,0,0,0,0, 0, 0,1,1);
        expect_outs("halt_hold", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0,0,0,0,0, 0, 0,0,1);
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("run3", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset asserted mid-operation takes effect immediately.
        step(0,0,0,0,0, 1, 0,0,0);
        async_reset = 1'b1;
        #1;
        expect_outs("mid_reset", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        async_reset = 1'b0;
        step(0,0,0,0,0, 0, 0,0,1);
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("reboot_run", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Three redirects, then one stall cycle.
        for (int i = 0; i < 3; i++) begin
            step(0,1,0,0,0, 0, 0,0,1);
            expect_outs("jump", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        step(0,0,0,0,0, 0, 1,0,1);
        expect_outs("stall", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef FETCH_SEQ_PERF_EN
        check("redirect_count", redirect_count, 32'd3);
        check("stall_count0", stall_count, 32'd0);
`endif
        step(0,0,0,0,0, 0, 0,0,1);
        expect_outs("final", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_SEQ_PERF_EN
        check("stall_count1", stall_count, 32'd1);
        check("redirect_hold", redirect_count, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
